// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data-memory loads/stores over a req/ready handshake, load align/extend, store strobes.
// Latency: 1 cycle for non-memory ops and errors; 1 + k cycles for memory ops (k >= 1 cycles waiting on dmem_ready).
// Backpressure: stall_out is high for the whole outstanding access; upstream holds its instruction until IDLE.
//
// Ports:
//   clk, reset (async, active-low)
//   valid_in, alu_result_in, store_data_in, rd_in, reg_write_in, mem_read_in, mem_write_in, funct3_in : EX/MEM register
//   stall_out                                                  : hold upstream
//   dmem_req/we/addr/wdata/wstrb, dmem_rdata, dmem_ready       : data memory port
//   valid_out, alu_result_out, mem_data_out, rd_out,
//   reg_write_out, mem_to_reg_out, err_out                     : registered result to WB
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        valid_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        err_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]  state_q, state_d;

  // Instruction fields held while the access is outstanding.
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;

  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;

  logic        valid_out_q, valid_out_d;
  logic [31:0] alu_result_out_q, alu_result_out_d;
  logic [31:0] mem_data_out_q, mem_data_out_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        reg_write_out_q, reg_write_out_d;
  logic        mem_to_reg_out_q, mem_to_reg_out_d;
  logic        err_out_q, err_out_d;

  // Decode of the incoming instruction.
  logic        is_mem;
  logic        bad_f3;
  logic        misalign;
  logic        illegal;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_shift;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    is_mem   = mem_read_in | mem_write_in;
    bad_f3   = (funct3_in == 3'b011) || (funct3_in[2:1] == 2'b11);
    misalign = ((funct3_in[1:0] == 2'b01) && alu_result_in[0]) ||
               ((funct3_in[1:0] == 2'b10) && (alu_result_in[1:0] != 2'b00));
    illegal  = is_mem && (bad_f3 || misalign || (mem_read_in && mem_write_in));
  end

  // Store lane replication: the memory picks the lanes via the strobes.
  always_comb begin
    st_strb = 4'b1111;
    st_data = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        st_strb = 4'b0001 << alu_result_in[1:0];
        st_data = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        st_strb = alu_result_in[1] ? 4'b1100 : 4'b0011;
        st_data = {2{store_data_in[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = store_data_in;
      end
    endcase
  end

  // Load lane select and extension, using the latched address offset.
  always_comb begin
    ld_shift = dmem_rdata >> {addr_lo_q, 3'b000};
    ld_half  = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    is_load_d        = is_load_q;
    funct3_d         = funct3_q;
    addr_lo_d        = addr_lo_q;
    alu_d            = alu_q;
    rd_d             = rd_q;
    rw_d             = rw_q;
    dmem_req_d       = dmem_req_q;
    dmem_we_d        = dmem_we_q;
    dmem_addr_d      = dmem_addr_q;
    dmem_wdata_d     = dmem_wdata_q;
    dmem_wstrb_d     = dmem_wstrb_q;
    valid_out_d      = 1'b0;
    alu_result_out_d = alu_result_out_q;
    mem_data_out_d   = mem_data_out_q;
    rd_out_d         = rd_out_q;
    reg_write_out_d  = 1'b0;
    mem_to_reg_out_d = mem_to_reg_out_q;
    err_out_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (!is_mem || illegal) begin
            // Plain op or rejected access: result next edge, no memory traffic.
            valid_out_d      = 1'b1;
            alu_result_out_d = alu_result_in;
            mem_data_out_d   = 32'h0;
            rd_out_d         = rd_in;
            reg_write_out_d  = illegal ? 1'b0 : reg_write_in;
            mem_to_reg_out_d = 1'b0;
            err_out_d        = illegal;
          end else begin
            state_d      = ST_REQ;
            is_load_d    = mem_read_in;
            funct3_d     = funct3_in;
            addr_lo_d    = alu_result_in[1:0];
            alu_d        = alu_result_in;
            rd_d         = rd_in;
            rw_d         = reg_write_in;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write_in;
            dmem_addr_d  = {alu_result_in[31:2], 2'b00};
            dmem_wdata_d = mem_write_in ? st_data : 32'h0;
            dmem_wstrb_d = mem_write_in ? st_strb : 4'b0000;
          end
        end
      end
      ST_REQ: begin
        // dmem_* registers hold their values until the memory completes.
        if (dmem_ready) begin
          state_d          = ST_IDLE;
          dmem_req_d       = 1'b0;
          valid_out_d      = 1'b1;
          alu_result_out_d = alu_q;
          mem_data_out_d   = is_load_q ? ld_ext : 32'h0;
          rd_out_d         = rd_q;
          reg_write_out_d  = is_load_q & rw_q;
          mem_to_reg_out_d = is_load_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      is_load_q        <= 1'b0;
      funct3_q         <= 3'b0;
      addr_lo_q        <= 2'b0;
      alu_q            <= 32'h0;
      rd_q             <= 5'h0;
      rw_q             <= 1'b0;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= 32'h0;
      dmem_wdata_q     <= 32'h0;
      dmem_wstrb_q     <= 4'h0;
      valid_out_q      <= 1'b0;
      alu_result_out_q <= 32'h0;
      mem_data_out_q   <= 32'h0;
      rd_out_q         <= 5'h0;
      reg_write_out_q  <= 1'b0;
      mem_to_reg_out_q <= 1'b0;
      err_out_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      is_load_q        <= is_load_d;
      funct3_q         <= funct3_d;
      addr_lo_q        <= addr_lo_d;
      alu_q            <= alu_d;
      rd_q             <= rd_d;
      rw_q             <= rw_d;
      dmem_req_q       <= dmem_req_d;
      dmem_we_q        <= dmem_we_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_wdata_q     <= dmem_wdata_d;
      dmem_wstrb_q     <= dmem_wstrb_d;
      valid_out_q      <= valid_out_d;
      alu_result_out_q <= alu_result_out_d;
      mem_data_out_q   <= mem_data_out_d;
      rd_out_q         <= rd_out_d;
      reg_write_out_q  <= reg_write_out_d;
      mem_to_reg_out_q <= mem_to_reg_out_d;
      err_out_q        <= err_out_d;
    end
  end

  assign stall_out      = (state_q == ST_REQ);
  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_wstrb     = dmem_wstrb_q;
  assign valid_out      = valid_out_q;
  assign alu_result_out = alu_result_out_q;
  assign mem_data_out   = mem_data_out_q;
  assign rd_out         = rd_out_q;
  assign reg_write_out  = reg_write_out_q;
  assign mem_to_reg_out = mem_to_reg_out_q;
  assign err_out        = err_out_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] alu_result_in = 32'h0;
  logic [31:0] store_data_in = 32'h0;
  logic [4:0]  rd_in = 5'h0;
  logic        reg_write_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [2:0]  funct3_in = 3'b0;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_ready = 1'b0;
  logic        valid_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_data_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        mem_to_reg_out;
  logic        err_out;

  int n_cmp = 0;
  int n_fail = 0;

  // Expected WB payload: {alu, mem_data, rd, reg_write, mem_to_reg, err}
  logic [71:0] exp_q[$];
  logic [71:0] exp_v;
  logic [71:0] obs_v;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .valid_out(valid_out), .alu_result_out(alu_result_out),
    .mem_data_out(mem_data_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [2:0] f3);
    valid_in = v; alu_result_in = alu; store_data_in = sd; rd_in = rd;
    reg_write_in = rw; mem_read_in = mr; mem_write_in = mw; funct3_in = f3;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    obs_v = {dmem_req, dmem_we, dmem_addr[7:0], dmem_wstrb, valid_out, alu_result_out[7:0],
             mem_data_out[7:0], rd_out, reg_write_out, mem_to_reg_out, err_out, stall_out, 35'h0};
    if (obs_v !== 72'h0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", obs_v);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({valid_out, stall_out, dmem_req} !== 3'b000) begin
      n_fail++; $display("FAIL after_reset_idle: got %b want 000", {valid_out, stall_out, dmem_req});
    end
  endtask

  task automatic test_add();
    bit saw_stall;
    saw_stall = 0;
    drive(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back({32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    saw_stall = saw_stall | stall_out;
    idle_inputs();
    exp_v = exp_q.pop_front();
    obs_v = {alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, err_out};
    n_cmp++;
    if (valid_out !== 1'b1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL add_result: got v=%b %h want v=1 %h", valid_out, obs_v, exp_v);
    end
    @(negedge clk);
    saw_stall = saw_stall | stall_out;
    n_cmp++;
    if (valid_out !== 1'b0 || reg_write_out !== 1'b0 || saw_stall) begin
      n_fail++; $display("FAIL add_idle: got v=%b rw=%b stall_seen=%b want 0 0 0",
                         valid_out, reg_write_out, saw_stall);
    end
  endtask

  // Load at addr with funct3, memory answers on the first REQ cycle.
  task automatic test_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp_data);
    drive(1'b1, addr, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, f3);
    exp_q.push_back({addr, exp_data, 5'd3, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if ({stall_out, dmem_req, dmem_we, dmem_wstrb, valid_out} !== 8'b1100_0000 ||
        dmem_addr !== {addr[31:2], 2'b00}) begin
      n_fail++; $display("FAIL %s_req: got st/req/we/strb/v=%b addr=%h want 11000000 addr=%h",
                         nm, {stall_out, dmem_req, dmem_we, dmem_wstrb, valid_out}, dmem_addr,
                         {addr[31:2], 2'b00});
    end
    dmem_rdata = rdata; dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    exp_v = exp_q.pop_front();
    obs_v = {alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, err_out};
    n_cmp++;
    if (valid_out !== 1'b1 || dmem_req !== 1'b0 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL %s_result: got v=%b req=%b %h want v=1 req=0 %h",
                         nm, valid_out, dmem_req, obs_v, exp_v);
    end
  endtask

  task automatic test_store_half();
    drive(1'b1, 32'h0000_0202, 32'h0000_ABCD, 5'd9, 1'b1, 1'b0, 1'b1, 3'b001);
    exp_q.push_back({32'h0000_0202, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_wstrb} !== 6'b11_1100 || dmem_addr !== 32'h200 ||
        dmem_wdata !== 32'hABCD_ABCD) begin
      n_fail++; $display("FAIL sh_req: got req/we/strb=%b addr=%h wdata=%h want 111100 200 abcdabcd",
                         {dmem_req, dmem_we, dmem_wstrb}, dmem_addr, dmem_wdata);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    exp_v = exp_q.pop_front();
    obs_v = {alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, err_out};
    n_cmp++;
    if (valid_out !== 1'b1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL sh_result: got v=%b %h want v=1 %h", valid_out, obs_v, exp_v);
    end
    // Byte store at lane 1 exercises the shifted strobe.
    drive(1'b1, 32'h0000_0305, 32'h1234_56A7, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (dmem_wstrb !== 4'b0010 || dmem_wdata !== 32'hA7A7_A7A7 || dmem_addr !== 32'h304) begin
      n_fail++; $display("FAIL sb_req: got strb=%b wdata=%h addr=%h want 0010 a7a7a7a7 304",
                         dmem_wstrb, dmem_wdata, dmem_addr);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
  endtask

  task automatic test_load_wait();
    logic [31:0] a0; logic [31:0] w0; logic [3:0] s0;
    int bad;
    bad = 0;
    drive(1'b1, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b010);
    exp_q.push_back({32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    idle_inputs();
    a0 = dmem_addr; w0 = dmem_wdata; s0 = dmem_wstrb;
    for (int i = 0; i < 3; i++) begin
      if (!stall_out || !dmem_req || valid_out || dmem_addr !== a0 || dmem_wdata !== w0 ||
          dmem_wstrb !== s0 || dmem_addr !== 32'h100) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0 || !stall_out || !dmem_req || valid_out) begin
      n_fail++; $display("FAIL lw_wait_hold: got %0d bad cycles stall=%b req=%b v=%b want 0 1 1 0",
                         bad, stall_out, dmem_req, valid_out);
    end
    dmem_rdata = 32'hDEAD_BEEF; dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    exp_v = exp_q.pop_front();
    obs_v = {alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, err_out};
    n_cmp++;
    if (valid_out !== 1'b1 || stall_out !== 1'b0 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL lw_wait_result: got v=%b stall=%b %h want v=1 stall=0 %h",
                         valid_out, stall_out, obs_v, exp_v);
    end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 32'h0000_0102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
    exp_q.push_back({32'h0000_0102, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    idle_inputs();
    exp_v = exp_q.pop_front();
    obs_v = {alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, err_out};
    n_cmp++;
    if (valid_out !== 1'b1 || dmem_req !== 1'b0 || stall_out !== 1'b0 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL lw_misaligned: got v=%b req=%b stall=%b %h want 1 0 0 %h",
                         valid_out, dmem_req, stall_out, obs_v, exp_v);
    end
    @(negedge clk);
    n_cmp++;
    if (err_out !== 1'b0 || valid_out !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse: got err=%b v=%b want 0 0", err_out, valid_out);
    end
    // Illegal funct3 on a store is rejected the same way.
    drive(1'b1, 32'h0000_0400, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 3'b011);
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if ({valid_out, err_out, dmem_req, reg_write_out} !== 4'b1100) begin
      n_fail++; $display("FAIL illegal_f3: got v/err/req/rw=%b want 1100",
                         {valid_out, err_out, dmem_req, reg_write_out});
    end
  endtask

  // Next instruction is held upstream during the stall and consumed only once back in IDLE.
  task automatic test_back_to_back();
    drive(1'b1, 32'h0000_0040, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b101);
    exp_q.push_back({32'h0000_0040, 32'h0000_8001, 5'd8, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    drive(1'b1, 32'h0000_0777, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back({32'h0000_0777, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0});
    dmem_rdata = 32'h1234_8001; dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    exp_v = exp_q.pop_front();
    obs_v = {alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, err_out};
    n_cmp++;
    if (valid_out !== 1'b1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL b2b_lhu: got v=%b %h want v=1 %h", valid_out, obs_v, exp_v);
    end
    @(negedge clk);
    idle_inputs();
    exp_v = exp_q.pop_front();
    obs_v = {alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, err_out};
    n_cmp++;
    if (valid_out !== 1'b1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL b2b_add: got v=%b %h want v=1 %h", valid_out, obs_v, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    drive(1'b1, 32'h0000_0580, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010);
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_req: got %b want 1", dmem_req);
    end
    #2 reset = 1'b0;
    #1;
    obs_v = {dmem_req, dmem_we, dmem_addr[7:0], dmem_wstrb, valid_out, alu_result_out[7:0],
             mem_data_out[7:0], rd_out, reg_write_out, mem_to_reg_out, err_out, stall_out, 35'h0};
    n_cmp++;
    if (obs_v !== 72'h0 || dmem_addr !== 32'h0 || alu_result_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_req: got %h addr=%h alu=%h want all 0",
                         obs_v, dmem_addr, alu_result_out);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    n_cmp++;
    if (valid_out !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_result: got v=%b req=%b want 0 0", valid_out, dmem_req);
    end
    drive(1'b1, 32'h0000_00AA, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back({32'h0000_00AA, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    idle_inputs();
    exp_v = exp_q.pop_front();
    obs_v = {alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, err_out};
    n_cmp++;
    if (valid_out !== 1'b1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL add_after_reset: got v=%b %h want v=1 %h", valid_out, obs_v, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load("lb", 32'h0000_0103, 3'b000, 32'h80FF_0011, 32'hFFFF_FF80);
    test_load("lbu", 32'h0000_0103, 3'b100, 32'h80FF_0011, 32'h0000_0080);
    test_load("lh", 32'h0000_0102, 3'b001, 32'h80FF_0011, 32'hFFFF_80FF);
    test_store_half();
    test_load_wait();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_req();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage sitting between the EX/MEM register and the WB stage. It performs data-memory loads and stores over a request/ready handshake, aligns and sign-extends load data, and builds byte strobes for stores. It presents a registered result (ALU value, load data, destination, write enable and explicit select flag) directly to WB. It stalls the upstream pipeline while a memory access is outstanding.

## Interface
Parameters: none.

- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- valid_in  in  1  upstream instruction valid
- alu_result_in  in  32  ALU result; effective address for memory ops
- store_data_in  in  32  rs2 value for stores
- rd_in  in  5  destination register
- reg_write_in  in  1  instruction writes rd
- mem_read_in  in  1  load instruction
- mem_write_in  in  1  store instruction
- funct3_in  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- stall_out  out  1  upstream must hold its current instruction
- dmem_req  out  1  memory request active
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte write strobes (0 for reads)
- dmem_rdata  in  32  read data, valid when dmem_ready = 1
- dmem_ready  in  1  access complete this cycle
- valid_out  out  1  result valid to WB
- alu_result_out  out  32  passed-through ALU result
- mem_data_out  out  32  extended load data (0 for non-loads)
- rd_out  out  5  destination register to WB
- reg_write_out  out  1  write enable to WB
- mem_to_reg_out  out  1  1 = WB selects mem_data_out, 0 = alu_result_out
- err_out  out  1  misaligned or illegal access, one-cycle pulse with valid_out

## Operation
- FSM states: IDLE, REQ. Reset state IDLE.
- IDLE, valid_in = 0: next edge valid_out = 0, reg_write_out = 0, err_out = 0.
- IDLE, valid_in = 1, no mem op: next edge output registers load the inputs, valid_out = 1, mem_to_reg_out = 0, mem_data_out = 0.
- IDLE, legal aligned mem op: latch the instruction, go to REQ; drive dmem_req = 1, dmem_addr, dmem_we, dmem_wdata, and dmem_wstrb from registers.
- REQ: dmem_req and dmem outputs are held stable until dmem_ready = 1. At that edge:
  - Capture and extend the load data.
  - Write the output registers: valid_out = 1; mem_to_reg_out = 1 for loads; reg_write_out = latched reg_write for loads, 0 for stores.
  - Return to IDLE; dmem_req = 0 from that edge.
- While in REQ, valid_out = 0 (bubble to WB).
- Error/illegal conditions: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] ≠ 0; funct3 011/110/111 on a mem op; mem_read_in and mem_write_in both 1.
  - Response: no memory request; next edge valid_out = 1, err_out = 1, reg_write_out = 0.
- Load extraction: select byte lane addr[1:0] or half lane addr[1].
  - Sign-extend for B/H; zero-extend for BU/HU; W passes through.
- Store strobes:
  - SB: wstrb = 1 << addr[1:0], wdata = byte replicated ×4.
  - SH: wstrb = 0011 (addr[1] = 0) or 1100 (addr[1] = 1), wdata = half replicated ×2.
  - SW: wstrb = 1111.
- stall_out = (state == REQ), combinational.

## Timing
- Reset (reset = 0, asynchronous): state IDLE; every output register is 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, valid_out, alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, err_out). stall_out = 0.
- Reset during REQ: dmem_req drops immediately; the pending access produces no result.
- Non-memory op: 1-cycle latency (valid_in at edge N, valid_out after edge N).
- Memory op: accepted at edge N; dmem_req high from N. If dmem_ready is high at edge N+k (k ≥ 1), the result appears after edge N+k. Minimum latency is 2 cycles.
- stall_out is high for cycles N+1 … N+k. The upstream instruction presented during those cycles is not consumed until IDLE.
- The memory must not see dmem_req deassert before dmem_ready. dmem_ready while dmem_req = 0 is ignored.

## Test plan
- ADD passthrough: valid_in = 1, alu_result_in = 0x0000_1234, rd = 5, reg_write = 1 → next cycle valid_out = 1, alu_result_out = 0x1234, rd_out = 5, mem_to_reg_out = 0, stall_out never high.
- LB at 0x103, dmem_rdata = 0x80FF_0011, ready on first REQ cycle → mem_data_out = 0xFFFF_FF80, mem_to_reg_out = 1. LBU at the same address → 0x0000_0080.
- SH at 0x202, store_data = 0x0000_ABCD → dmem_addr = 0x200, dmem_wstrb = 1100, dmem_wdata = 0xABCD_ABCD, dmem_we = 1; result reg_write_out = 0.
- LW with dmem_ready delayed 3 cycles → stall_out high 3 cycles, dmem outputs stable, valid_out = 0 throughout, result appears on the 4th edge after accept.
- LW at 0x102 → no dmem_req; next cycle valid_out = 1, err_out = 1, reg_write_out = 0.
- Assert reset = 0 mid-REQ → dmem_req = 0 and all outputs 0 immediately; after release, an ADD passes normally.
